// File: rtl/aes_iter_core.sv
// Iterative AES encryption core: one round per clock, one shared round datapath.
// Round keys are loaded externally into an (NR_MAX+1)-entry store while idle.
module aes_iter_core #(
  parameter int NR_MAX = 14,
  parameter int KIDX_W = 4
) (
  input  logic              clk_in,
  input  logic              rst_in,
  input  logic              key_wr_en_in,
  input  logic [KIDX_W-1:0] key_wr_idx_in,
  input  logic [127:0]      key_wr_data_in,
  input  logic [1:0]        key_len_in,
  input  logic              in_valid_in,
  output logic              in_ready_out,
  input  logic [127:0]      user_plain_txt_in,
  output logic              out_valid_out,
  input  logic              out_ready_in,
  output logic [127:0]      cipher_encrypted_text_out,
  output logic              busy_out
);

  localparam int CNT_W = $clog2(NR_MAX + 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ROUND = 2'd1,
    DONE  = 2'd2
  } fsm_t;

  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a,
                                      input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = xtime(x);
    end
    return p;
  endfunction

  // S-box from its definition: inverse as a^254, then the affine map.
  function automatic logic [7:0] sbox(input logic [7:0] a);
    logic [7:0] sq;
    logic [7:0] inv;
    logic [7:0] r;
    sq  = gmul(a, a);
    inv = sq;
    for (int i = 0; i < 6; i++) begin
      sq  = gmul(sq, sq);
      inv = gmul(inv, sq);
    end
    r = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]}
      ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
    return r;
  endfunction

  function automatic logic [127:0] sub_bytes(input logic [127:0] s);
    logic [127:0] o;
    for (int i = 0; i < 16; i++)
      o[i*8 +: 8] = sbox(s[i*8 +: 8]);
    return o;
  endfunction

  // Byte k sits at [127-8k -: 8]; byte index = 4*col + row.
  function automatic logic [127:0] shift_rows(input logic [127:0] s);
    logic [127:0] o;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        o[127-8*(4*c+r) -: 8] = s[127-8*(4*((c+r)%4)+r) -: 8];
    return o;
  endfunction

  function automatic logic [127:0] mix_columns(input logic [127:0] s);
    logic [127:0] o;
    logic [7:0]   a0, a1, a2, a3;
    for (int c = 0; c < 4; c++) begin
      a0 = s[127-8*(4*c)   -: 8];
      a1 = s[127-8*(4*c+1) -: 8];
      a2 = s[127-8*(4*c+2) -: 8];
      a3 = s[127-8*(4*c+3) -: 8];
      o[127-8*(4*c)   -: 8] = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
      o[127-8*(4*c+1) -: 8] = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
      o[127-8*(4*c+2) -: 8] = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
      o[127-8*(4*c+3) -: 8] = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
    end
    return o;
  endfunction

  fsm_t             fsm_q, fsm_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] nr_q, nr_d;
  logic             out_valid_q, out_valid_d;
  logic [127:0]     state_q, state_d;
  logic [127:0]     rk_q [NR_MAX+1];
  logic [127:0]     rk_d [NR_MAX+1];

  logic [127:0] rk_cur;
  logic [127:0] sr_out;
  logic [127:0] round_out;

  always_comb begin
    rk_cur = '0;
    for (int i = 0; i <= NR_MAX; i++)
      if (cnt_q == CNT_W'(i)) rk_cur = rk_q[i];
  end

  always_comb begin
    sr_out    = shift_rows(sub_bytes(state_q));
    round_out = (cnt_q == nr_q) ? (sr_out ^ rk_cur)
                                : (mix_columns(sr_out) ^ rk_cur);
  end

  always_comb begin
    fsm_d       = fsm_q;
    cnt_d       = cnt_q;
    nr_d        = nr_q;
    out_valid_d = out_valid_q;
    state_d     = state_q;
    rk_d        = rk_q;
    unique case (fsm_q)
      IDLE: begin
        // Accept reads the pre-write rk[0] from the register.
        if (key_wr_en_in) begin
          for (int i = 0; i <= NR_MAX; i++)
            if (key_wr_idx_in == KIDX_W'(i)) rk_d[i] = key_wr_data_in;
        end
        if (in_valid_in) begin
          state_d = user_plain_txt_in ^ rk_q[0];
          cnt_d   = CNT_W'(1);
          fsm_d   = ROUND;
          unique case (key_len_in)
            2'b00:   nr_d = CNT_W'(10);
            2'b01:   nr_d = CNT_W'(12);
            default: nr_d = CNT_W'(14);
          endcase
        end
      end
      ROUND: begin
        state_d = round_out;
        if (cnt_q == nr_q) begin
          fsm_d       = DONE;
          out_valid_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      DONE: begin
        if (out_ready_in) begin
          out_valid_d = 1'b0;
          fsm_d       = IDLE;
        end
      end
      default: fsm_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      fsm_q       <= IDLE;
      cnt_q       <= '0;
      nr_q        <= '0;
      out_valid_q <= 1'b0;
      state_q     <= '0;
      for (int i = 0; i <= NR_MAX; i++) rk_q[i] <= '0;
    end else begin
      fsm_q       <= fsm_d;
      cnt_q       <= cnt_d;
      nr_q        <= nr_d;
      out_valid_q <= out_valid_d;
      state_q     <= state_d;
      for (int i = 0; i <= NR_MAX; i++) rk_q[i] <= rk_d[i];
    end
  end

  assign in_ready_out              = (fsm_q == IDLE);
  assign busy_out                  = (fsm_q != IDLE);
  assign out_valid_out             = out_valid_q;
  assign cipher_encrypted_text_out = state_q;

endmodule

// File: tb/tb_aes_iter_core.sv
// Directed bench for aes_iter_core: FIPS-197 vectors, latency,
// backpressure, key freezing and reset behaviour.
module tb_aes_iter_core;

  logic         clk;
  logic         rst;
  logic         key_wr_en;
  logic [3:0]   key_wr_idx;
  logic [127:0] key_wr_data;
  logic [1:0]   key_len;
  logic         in_valid;
  logic         in_ready;
  logic [127:0] pt;
  logic         out_valid;
  logic         out_ready;
  logic [127:0] ct;
  logic         busy;

  aes_iter_core #(.NR_MAX(14), .KIDX_W(4)) dut (
    .clk_in                    (clk),
    .rst_in                    (rst),
    .key_wr_en_in              (key_wr_en),
    .key_wr_idx_in             (key_wr_idx),
    .key_wr_data_in            (key_wr_data),
    .key_len_in                (key_len),
    .in_valid_in               (in_valid),
    .in_ready_out              (in_ready),
    .user_plain_txt_in         (pt),
    .out_valid_out             (out_valid),
    .out_ready_in              (out_ready),
    .cipher_encrypted_text_out (ct),
    .busy_out                  (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  localparam logic [127:0] PT   = 128'h00112233445566778899aabbccddeeff;
  localparam logic [255:0] K128 = {128'h000102030405060708090a0b0c0d0e0f, 128'h0};
  localparam logic [255:0] K192 = {192'h000102030405060708090a0b0c0d0e0f1011121314151617, 64'h0};
  localparam logic [255:0] K256 = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
  localparam logic [127:0] C128 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] C192 = 128'hdda97ca4864cdfe06eaf70a0ec0d7191;
  localparam logic [127:0] C256 = 128'h8ea2b7ca516745bfeafc49904b496089;
  localparam logic [127:0] ONES = {128{1'b1}};

  int vectors    = 0;
  int miscompares = 0;

  logic [7:0]   sb       [256];
  logic [31:0]  w        [60];
  logic [127:0] rk_model [15];

  task automatic chk(input string tag, input logic [127:0] obs,
                     input logic [127:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] gm(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    logic [7:0] y;
    p = 0; x = a; y = b;
    for (int i = 0; i < 8; i++) begin
      if (y[0]) p = p ^ x;
      x = x[7] ? ({x[6:0], 1'b0} ^ 8'h1b) : {x[6:0], 1'b0};
      y = y >> 1;
    end
    return p;
  endfunction

  // Table built by brute-force inverse search plus the affine map.
  task automatic build_sbox();
    logic [7:0] inv;
    logic [7:0] s;
    logic [7:0] rot;
    for (int a = 0; a < 256; a++) begin
      inv = 0;
      for (int b = 1; b < 256; b++)
        if (gm(8'(a), 8'(b)) == 8'h01) inv = 8'(b);
      s = inv ^ 8'h63;
      rot = inv;
      for (int k = 0; k < 4; k++) begin
        rot = {rot[6:0], rot[7]};
        s = s ^ rot;
      end
      sb[a] = s;
    end
  endtask

  function automatic logic [31:0] subw(input logic [31:0] t);
    return {sb[t[31:24]], sb[t[23:16]], sb[t[15:8]], sb[t[7:0]]};
  endfunction

  task automatic expand(input logic [255:0] key, input int nk);
    logic [31:0] tmp;
    logic [7:0]  rc;
    int          nr;
    nr = nk + 6;
    rc = 8'h01;
    for (int i = 0; i < nk; i++) w[i] = key[255-32*i -: 32];
    for (int i = nk; i < 4*(nr+1); i++) begin
      tmp = w[i-1];
      if (i % nk == 0) begin
        tmp = subw({tmp[23:0], tmp[31:24]}) ^ {rc, 24'h0};
        rc = gm(rc, 8'h02);
      end else if (nk > 6 && i % nk == 4) begin
        tmp = subw(tmp);
      end
      w[i] = w[i-nk] ^ tmp;
    end
    for (int r = 0; r <= nr; r++)
      rk_model[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  endtask

  function automatic logic [127:0] model_enc(input logic [127:0] p, input int nr);
    logic [7:0]   s [16];
    logic [7:0]   t [16];
    logic [7:0]   a0, a1, a2, a3;
    logic [127:0] o;
    for (int i = 0; i < 16; i++)
      s[i] = p[127-8*i -: 8] ^ rk_model[0][127-8*i -: 8];
    for (int r = 1; r <= nr; r++) begin
      for (int c = 0; c < 4; c++)
        for (int q = 0; q < 4; q++)
          t[4*c+q] = sb[s[4*((c+q)%4)+q]];
      for (int c = 0; c < 4; c++) begin
        a0 = t[4*c]; a1 = t[4*c+1]; a2 = t[4*c+2]; a3 = t[4*c+3];
        if (r < nr) begin
          s[4*c]   = gm(a0, 2) ^ gm(a1, 3) ^ a2 ^ a3;
          s[4*c+1] = a0 ^ gm(a1, 2) ^ gm(a2, 3) ^ a3;
          s[4*c+2] = a0 ^ a1 ^ gm(a2, 2) ^ gm(a3, 3);
          s[4*c+3] = gm(a0, 3) ^ a1 ^ a2 ^ gm(a3, 2);
        end else begin
          s[4*c] = a0; s[4*c+1] = a1; s[4*c+2] = a2; s[4*c+3] = a3;
        end
      end
      for (int i = 0; i < 16; i++)
        s[i] = s[i] ^ rk_model[r][127-8*i -: 8];
    end
    for (int i = 0; i < 16; i++) o[127-8*i -: 8] = s[i];
    return o;
  endfunction

  task automatic load_keys(input logic [255:0] key, input int nk);
    expand(key, nk);
    for (int r = 0; r <= nk + 6; r++) begin
      key_wr_en   = 1'b1;
      key_wr_idx  = 4'(r);
      key_wr_data = rk_model[r];
      @(negedge clk);
    end
    key_wr_en = 1'b0;
  endtask

  // inj > 0: write rk[0]=ones after inj round edges; inj < 0: on accept edge.
  task automatic run_block(input string tag, input logic [127:0] p,
                           input logic [1:0] kl, input int nr,
                           input logic [127:0] exp, input int inj);
    int n;
    in_valid = 1'b1;
    pt       = p;
    key_len  = kl;
    if (inj < 0) begin
      key_wr_en = 1'b1; key_wr_idx = 4'd0; key_wr_data = ONES;
    end
    @(negedge clk);
    in_valid  = 1'b0;
    key_wr_en = 1'b0;
    chk({tag, "_busy"}, 128'(busy), 128'(1));
    chk({tag, "_inrdy"}, 128'(in_ready), 128'(0));
    n = 0;
    while (!out_valid && n < 40) begin
      if (inj > 0 && n == inj) begin
        key_wr_en = 1'b1; key_wr_idx = 4'd0; key_wr_data = ONES;
      end else begin
        key_wr_en = 1'b0;
      end
      @(negedge clk);
      n++;
    end
    key_wr_en = 1'b0;
    chk({tag, "_latency"}, 128'(n), 128'(nr));
    chk({tag, "_ct"}, ct, exp);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk({tag, "_hs_valid"}, 128'(out_valid), 128'(0));
    chk({tag, "_hs_inrdy"}, 128'(in_ready), 128'(1));
  endtask

  initial begin
    int n;
    int seen;
    logic [127:0] exp;
    rst = 1'b1; key_wr_en = 1'b0; key_wr_idx = '0; key_wr_data = '0;
    key_len = 2'b00; in_valid = 1'b0; pt = '0; out_ready = 1'b0;
    build_sbox();
    repeat (2) @(negedge clk);
    rst = 1'b0;
    chk("rst_inrdy", 128'(in_ready), 128'(1));
    chk("rst_valid", 128'(out_valid), 128'(0));
    chk("rst_busy", 128'(busy), 128'(0));
    chk("rst_ct", ct, 128'h0);

    load_keys(K256, 8);
    run_block("aes256", PT, 2'b10, 14, C256, 0);

    // Backpressure in DONE with a competing plaintext request.
    in_valid = 1'b1; pt = PT; key_len = 2'b10;
    @(negedge clk);
    in_valid = 1'b0;
    n = 0;
    while (!out_valid && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk("bp_latency", 128'(n), 128'(14));
    in_valid = 1'b1; pt = ONES;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("bp_valid", 128'(out_valid), 128'(1));
      chk("bp_ct", ct, C256);
      chk("bp_inrdy", 128'(in_ready), 128'(0));
    end
    pt = PT;
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk("bp_hs_valid", 128'(out_valid), 128'(0));
    chk("bp_hs_inrdy", 128'(in_ready), 128'(1));
    run_block("bp_next", PT, 2'b10, 14, C256, 0);

    run_block("kw_round", PT, 2'b10, 14, C256, 3);
    run_block("kw_after", PT, 2'b10, 14, C256, 0);
    run_block("keylen11", PT, 2'b11, 14, C256, 0);

    load_keys(K128, 4);
    run_block("aes128", PT, 2'b00, 10, C128, 0);
    key_wr_en = 1'b1; key_wr_idx = 4'd15; key_wr_data = ONES;
    @(negedge clk);
    key_wr_en = 1'b0;
    run_block("idx15", PT, 2'b00, 10, C128, 0);

    run_block("same_edge", PT, 2'b00, 10, C128, -1);
    rk_model[0] = ONES;
    exp = model_enc(PT, 10);
    run_block("rk0_ones", PT, 2'b00, 10, exp, 0);

    load_keys(K192, 6);
    run_block("aes192", PT, 2'b01, 12, C192, 0);

    // Reset at round 7 of AES-256, racing a new accept and a key write.
    load_keys(K256, 8);
    in_valid = 1'b1; pt = PT; key_len = 2'b10;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (6) @(negedge clk);
    chk("pre_rst_busy", 128'(busy), 128'(1));
    rst = 1'b1; in_valid = 1'b1; out_ready = 1'b1;
    key_wr_en = 1'b1; key_wr_idx = 4'd0; key_wr_data = ONES;
    @(negedge clk);
    rst = 1'b0; in_valid = 1'b0; out_ready = 1'b0; key_wr_en = 1'b0;
    chk("mid_rst_inrdy", 128'(in_ready), 128'(1));
    chk("mid_rst_busy", 128'(busy), 128'(0));
    chk("mid_rst_ct", ct, 128'h0);
    seen = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (out_valid) seen++;
    end
    chk("mid_rst_no_valid", 128'(seen), 128'(0));
    for (int r = 0; r < 15; r++) rk_model[r] = '0;
    exp = model_enc(128'h0, 10);
    run_block("zero_keys", 128'h0, 2'b00, 10, exp, 0);
    exp = model_enc(128'h0, 14);
    run_block("zero_keys14", 128'h0, 2'b10, 14, exp, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
